// File: rtl/cpu_types_pkg.sv
// Shared MIPS datapath types: machine word, opcode encodings and field widths.
// Used by the fetch path and the datapath/cache interface.
package cpu_types_pkg;

  localparam int OP_W   = 6;
  localparam int ADDR_W = 26;

  typedef logic [31:0] word_t;

  typedef enum logic [OP_W-1:0] {
    J    = 6'b000010,
    JAL  = 6'b000011,
    HALT = 6'b111111
  } opcode_t;

endpackage

// File: rtl/datapath_cache_if.sv
// Datapath-to-cache bundle, reduced to the instruction-side request/response.
// The dp modport is the view seen by the fetch logic.
interface datapath_cache_if;
  import cpu_types_pkg::*;

  logic  ihit;
  logic  halt;
  logic  imemREN;
  word_t imemload;
  word_t imemaddr;

  modport dp (
    input  ihit, halt, imemload,
    output imemREN, imemaddr
  );
endinterface

// File: rtl/program_counter.sv
// Instruction-fetch PC: advances on ihit, redirects on J/JAL, freezes on halt until reset.
// One-cycle register latency; outputs depend on registers only, holds while ihit is low.
module program_counter
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input logic            CLK,
  input logic            nRST,
  datapath_cache_if.dp   dcif
);

  word_t             pc_q;
  logic              halted_q;
  word_t             w_pc_plus4;
  word_t             w_pc_next;
  logic              w_halted_next;
  logic [OP_W-1:0]   w_opcode;

  assign w_pc_plus4 = pc_q + 32'd4;
  assign w_opcode   = dcif.imemload[31 -: OP_W];

  assign dcif.imemaddr = pc_q;
  assign dcif.imemREN  = !halted_q;

  // Priority: frozen, external halt, then ihit-qualified opcode decode.
  // An X on ihit falls through to the hold path in simulation.
  always_comb begin
    w_pc_next     = pc_q;
    w_halted_next = halted_q;
    if (!halted_q) begin
      if (dcif.halt) begin
        w_halted_next = 1'b1;
      end else if (dcif.ihit) begin
        case (w_opcode)
          HALT:    w_halted_next = 1'b1;
          J, JAL:  w_pc_next = {w_pc_plus4[31:28], dcif.imemload[ADDR_W-1:0], 2'b00};
          default: w_pc_next = w_pc_plus4;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc_q     <= {PC_INIT[31:2], 2'b00};
      halted_q <= 1'b0;
    end else begin
      pc_q     <= w_pc_next;
      halted_q <= w_halted_next;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboarded bench for program_counter: directed plan cases plus a random phase,
// with separate instances for the high-region JAL and the address wrap.
module tb_program_counter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst_a, nrst_b, nrst_c;
  datapath_cache_if dif_a ();
  datapath_cache_if dif_b ();
  datapath_cache_if dif_c ();

  program_counter #(.PC_INIT(32'h0000_0000)) u_a (.CLK(clk), .nRST(nrst_a), .dcif(dif_a));
  program_counter #(.PC_INIT(32'h1000_0000)) u_b (.CLK(clk), .nRST(nrst_b), .dcif(dif_b));
  program_counter #(.PC_INIT(32'hFFFF_FFFC)) u_c (.CLK(clk), .nRST(nrst_c), .dcif(dif_c));

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  word_t       m_pc;
  logic        m_halt;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%09h expected 0x%09h", tag, obs, exp);
    end
  endtask

  // Reference model of one edge, applied to the bench's own copy of the state.
  task automatic model(input logic nrst, input logic ihit, input word_t load, input logic halt);
    word_t p4;
    p4 = m_pc + 32'd4;
    if (!nrst) begin
      m_pc = 32'h0; m_halt = 1'b0;
    end else if (m_halt) begin
    end else if (halt) begin
      m_halt = 1'b1;
    end else if (ihit) begin
      if (load[31:26] == 6'b111111)                                m_halt = 1'b1;
      else if (load[31:26] == 6'b000010 || load[31:26] == 6'b000011) m_pc = {p4[31:28], load[25:0], 2'b00};
      else                                                         m_pc = p4;
    end
  endtask

  task automatic step_a(input string tag, input logic nrst, input logic ihit,
                        input word_t load, input logic halt);
    logic [32:0] e;
    nrst_a = nrst; dif_a.ihit = ihit; dif_a.imemload = load; dif_a.halt = halt;
    model(nrst, ihit, load, halt);
    exp_q.push_back({m_pc, !m_halt});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk(tag, {dif_a.imemaddr, dif_a.imemREN}, e);
  endtask

  initial begin
    word_t ld;
    nrst_a = 1'b1; nrst_b = 1'b1; nrst_c = 1'b1;
    dif_a.ihit = 1'b0; dif_a.halt = 1'b0; dif_a.imemload = '0;
    dif_b.ihit = 1'b0; dif_b.halt = 1'b0; dif_b.imemload = '0;
    dif_c.ihit = 1'b0; dif_c.halt = 1'b0; dif_c.imemload = '0;
    m_pc = '0; m_halt = 1'b0;
    #2;

    step_a("reset", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset_const", {dif_a.imemaddr, dif_a.imemREN}, {32'h0, 1'b1});
    for (int i = 0; i < 10; i++) step_a("idle_hold", 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_a("nop_step", 1'b1, 1'b1, 32'h0, 1'b0);
      chk("nop_const", {dif_a.imemaddr, dif_a.imemREN}, {32'(4 * (i + 1)), 1'b1});
    end
    for (int i = 0; i < 2; i++) step_a("ihit_low_hold", 1'b1, 1'b0, 32'h0, 1'b0);
    chk("hold_c", {dif_a.imemaddr, dif_a.imemREN}, {32'h0000_000C, 1'b1});
    step_a("jump", 1'b1, 1'b1, 32'h0800_0010, 1'b0);
    chk("jump_const", {dif_a.imemaddr, dif_a.imemREN}, {32'h0000_0040, 1'b1});

    step_a("reset2", 1'b0, 1'b0, 32'h0, 1'b0);
    step_a("nop", 1'b1, 1'b1, 32'h0, 1'b0);
    step_a("nop", 1'b1, 1'b1, 32'h0, 1'b0);
    step_a("halt_beats_ihit", 1'b1, 1'b1, 32'h0, 1'b1);
    chk("halt_const", {dif_a.imemaddr, dif_a.imemREN}, {32'h0000_0008, 1'b0});
    step_a("halt_sticky", 1'b1, 1'b1, 32'h0, 1'b0);
    chk("sticky_const", {dif_a.imemaddr, dif_a.imemREN}, {32'h0000_0008, 1'b0});

    step_a("reset3", 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step_a("nop", 1'b1, 1'b1, 32'h0, 1'b0);
    step_a("halt_op", 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("halt_op_const", {dif_a.imemaddr, dif_a.imemREN}, {32'h0000_0014, 1'b0});
    step_a("reset_after_halt", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("restart_const", {dif_a.imemaddr, dif_a.imemREN}, {32'h0, 1'b1});
    step_a("nop", 1'b1, 1'b1, 32'h0, 1'b0);
    step_a("reset_beats_all", 1'b0, 1'b1, 32'h0800_0100, 1'b1);
    chk("reset_win_const", {dif_a.imemaddr, dif_a.imemREN}, {32'h0, 1'b1});

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0:       ld = 32'h0;
        1:       ld = {6'b000010, 26'($urandom)};
        2:       ld = {6'b000011, 26'($urandom)};
        3:       ld = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'h2108_0001;
        default: ld = $urandom;
      endcase
      step_a("random", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), ld,
             ($urandom_range(0, 29) == 0));
    end

    nrst_b = 1'b0; nrst_c = 1'b0;
    @(posedge clk); #1;
    nrst_b = 1'b1; nrst_c = 1'b1;
    chk("b_reset", {dif_b.imemaddr, dif_b.imemREN}, {32'h1000_0000, 1'b1});
    chk("c_reset", {dif_c.imemaddr, dif_c.imemREN}, {32'hFFFF_FFFC, 1'b1});
    dif_b.ihit = 1'b1; dif_b.imemload = 32'h0C00_0004;
    dif_c.ihit = 1'b1; dif_c.imemload = 32'h0;
    @(posedge clk); #1;
    dif_b.ihit = 1'b0; dif_c.ihit = 1'b0;
    chk("b_jal", {dif_b.imemaddr, dif_b.imemREN}, {32'h1000_0010, 1'b1});
    chk("c_wrap", {dif_c.imemaddr, dif_c.imemREN}, {32'h0000_0000, 1'b1});
    @(posedge clk); #1;
    chk("c_wrap_hold", {dif_c.imemaddr, dif_c.imemREN}, {32'h0000_0000, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Instruction-fetch program counter for the single-cycle MIPS datapath. It holds the current fetch address and drives the instruction-side request of `datapath_cache_if` (`imemaddr`, `imemREN`). It advances on each instruction hit, and redirects on J/JAL using the fetched word. It freezes permanently on halt, either from the `halt` signal or from a fetched HALT opcode, until reset.

## Interface
- `PC_INIT`, default `32'h0000_0000`: reset/boot fetch address; must be word-aligned.
- `CLK` input, 1 bit: system clock; all state updates on rising edge.
- `nRST` input, 1 bit: one clock; reset is synchronous and active-low.
- `dcif` (`datapath_cache_if`), bundle; `word_t` = 32 bits from `cpu_types_pkg`. Members used:
  - `dcif.ihit` input, 1 bit: instruction fetch completed this cycle; `imemload` is valid.
  - `dcif.imemload` input, 32 bits: fetched instruction word.
  - `dcif.halt` input, 1 bit: external halt request, sampled at the rising edge.
  - `dcif.imemREN` output, 1 bit: instruction read enable.
  - `dcif.imemaddr` output, 32 bits: fetch address, equal to the PC register.
- All other `dcif` members are not driven by this block.

## Operation
- State: `pc_q` (32 bits), `halted_q` (1 bit).
- `dcif.imemaddr = pc_q`; `dcif.imemREN = !halted_q`. Both are combinational from registers only.
- Opcode is `imemload[31:26]`. Next-PC selection, evaluated at each rising edge with `nRST=1`, first match wins:
  1. `halted_q=1`: `pc_q` and `halted_q` hold.
  2. `dcif.halt=1`: `halted_q<=1`, `pc_q` holds (halt beats a simultaneous ihit).
  3. `ihit=1` and opcode = HALT (`6'b111111`): `halted_q<=1`, `pc_q` holds.
  4. `ihit=1` and opcode ∈ {J `6'b000010`, JAL `6'b000011`}: `pc_q <= {pc_plus4[31:28], imemload[25:0], 2'b00}`.
  5. `ihit=1`, any other opcode: `pc_q <= pc_q + 4`. Branches and JR are sequential at this level.
  6. `ihit=0` (including X/undriven treated as not asserted): `pc_q` holds.
- `pc_plus4 = pc_q + 32'd4`, modulo 2^32. From `32'hFFFF_FFFC` it wraps to `0`.
- `pc_q[1:0]` is always `2'b00`. No path can produce a misaligned address.
- JAL link-register write is not this block's job.

## Timing
- Reset (`nRST=0` at an edge): `pc_q<=PC_INIT`, `halted_q<=0`. Next cycle `imemaddr=PC_INIT` and `imemREN=1`.
- Reset wins over `halt` and `ihit` at the same edge. Reset mid-run or after halt restarts fetching at `PC_INIT`.
- Latency: PC update is visible on `imemaddr` in the cycle after the edge that sampled `ihit` (1-cycle register).
- Halt: `imemREN` falls the cycle after the sampling edge and stays 0 even after `dcif.halt` deasserts.
- No combinational path from any `dcif` input to any `dcif` output.

## Structure
- `cpu_types_pkg` holds `word_t`, `opcode_t` with the J, JAL and HALT encodings, and the `OP_W=6`/`ADDR_W=26` field constants. This block defines no local typedefs.
- Next-PC mux is a single `always_comb`. Registers are in a single `always_ff` with synchronous reset.
- No sub-module is needed. An optional `pc_next_logic` holds the jump-target/increment mux if it is split out.

## Test plan
- Reset with `PC_INIT=0`, `ihit=0`, `halt=0` → `imemaddr=0x0`, `imemREN=1`, holding over 10 cycles.
- `ihit=1` for 3 cycles, `imemload=0x00000000` (NOP) → `imemaddr` steps 0x4, 0x8, 0xC. Dropping `ihit` for 2 cycles holds at 0xC.
- At `pc=0x0C`, `ihit=1`, `imemload=0x08000010` (J) → `imemaddr=0x40`. At `pc=0x1000_0000`, JAL `0x0C000004` → `0x1000_0010`.
- `halt=1` together with `ihit=1` at `pc=0x8` → `pc` stays 0x8, `imemREN=0` next cycle. Then `halt=0` and `ihit=1` → both unchanged.
- `ihit=1`, `imemload=0xFFFFFFFF` (HALT) at `pc=0x14` → `pc` stays 0x14, `imemREN=0`. `nRST=0` for one edge → `imemaddr=0x0`, `imemREN=1`.
- `PC_INIT=0xFFFFFFFC`, one `ihit` with NOP → `imemaddr=0x0` (wrap).
